// File: rtl/rca_config_readback.sv
// Streams one RCA configuration table out of the configuration storage as
// zero-extended XLEN words, one storage read per word, under valid/ready.
module rca_config_readback #(
    parameter int XLEN            = 32,
    parameter int NUM_RCAS        = 2,
    parameter int NUM_READ_PORTS  = 5,
    parameter int NUM_WRITE_PORTS = 2,
    parameter int NUM_IO_UNITS    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [3:0]                  req_rca_sel,
    input  logic [1:0]                  req_kind,
    output logic                        rd_en,
    output logic [$clog2(NUM_RCAS)-1:0] rd_rca,
    output logic [1:0]                  rd_kind,
    output logic [2:0]                  rd_idx,
    input  logic [XLEN-1:0]             rd_data,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [XLEN-1:0]             rsp_data,
    output logic                        rsp_last,
    output logic                        rsp_err
);

    localparam int RCA_W    = $clog2(NUM_RCAS);
    localparam int IO_SEL_W = $clog2(NUM_IO_UNITS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_SEND,
        ST_ERR
    } state_t;

    state_t           state_reg;
    logic [RCA_W-1:0] rca_reg;
    logic [1:0]       kind_reg;
    logic [3:0]       count_reg;
    logic [2:0]       idx_reg;
    logic [3:0]       req_count;
    logic             req_bad;
    logic [XLEN-1:0]  keep_mask;
    logic [XLEN-1:0]  capture_word;

    // Bits surviving the per-table mask: register addresses are 5 bits wide,
    // result-mux selects are IO_SEL_W bits wide, constants keep the full word.
    genvar gi;
    generate
        for (gi = 0; gi < XLEN; gi++) begin : g_mask
            assign keep_mask[gi] = (kind_reg == 2'd2) |
                                   ((kind_reg == 2'd3) ? (gi < IO_SEL_W) : (gi < 5));
        end
    endgenerate

    assign capture_word = rd_data & keep_mask;

    always_comb begin
        req_count = 4'(NUM_READ_PORTS);
        case (req_kind)
            2'd0:    req_count = 4'(NUM_READ_PORTS);
            2'd1:    req_count = 4'(NUM_WRITE_PORTS);
            2'd2:    req_count = 4'(NUM_IO_UNITS);
            default: req_count = 4'(NUM_WRITE_PORTS);
        endcase
    end

    assign req_bad   = (32'(req_rca_sel) >= 32'(NUM_RCAS));
    assign req_ready = (state_reg == ST_IDLE) && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            rca_reg   <= '0;
            kind_reg  <= '0;
            count_reg <= '0;
            idx_reg   <= '0;
            rd_en     <= 1'b0;
            rd_rca    <= '0;
            rd_kind   <= '0;
            rd_idx    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;
        end else if (flush) begin
            state_reg <= ST_IDLE;
            rd_en     <= 1'b0;
            rd_rca    <= '0;
            rd_kind   <= '0;
            rd_idx    <= '0;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        rca_reg   <= req_rca_sel[RCA_W-1:0];
                        kind_reg  <= req_kind;
                        count_reg <= req_count;
                        idx_reg   <= '0;
                        if (req_bad) begin
                            state_reg <= ST_ERR;
                            rsp_valid <= 1'b1;
                            rsp_data  <= '0;
                            rsp_last  <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            state_reg <= ST_ISSUE;
                            rd_en     <= 1'b1;
                            rd_rca    <= req_rca_sel[RCA_W-1:0];
                            rd_kind   <= req_kind;
                            rd_idx    <= '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    rd_en     <= 1'b0;
                    state_reg <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    rsp_data  <= capture_word;
                    rsp_last  <= ({1'b0, idx_reg} == (count_reg - 4'd1));
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    state_reg <= ST_SEND;
                end
                ST_SEND: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (rsp_last) begin
                            state_reg <= ST_IDLE;
                            rsp_last  <= 1'b0;
                            rd_rca    <= '0;
                            rd_kind   <= '0;
                            rd_idx    <= '0;
                        end else begin
                            idx_reg   <= 3'(idx_reg + 3'd1);
                            state_reg <= ST_ISSUE;
                            rd_en     <= 1'b1;
                            rd_rca    <= rca_reg;
                            rd_kind   <= kind_reg;
                            rd_idx    <= 3'(idx_reg + 3'd1);
                        end
                    end
                end
                ST_ERR: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_last  <= 1'b0;
                        rsp_err   <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rca_config_readback.sv
// Directed bench for rca_config_readback: storage model with one-cycle read
// latency, scoreboard of expected response words, stall/flush/reset checks.
module tb_rca_config_readback;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_rca_sel = '0;
    logic [1:0]  req_kind = '0;
    logic        rd_en;
    logic [0:0]  rd_rca;
    logic [1:0]  rd_kind;
    logic [2:0]  rd_idx;
    logic [31:0] rd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        rsp_err;

    always #5 clk = ~clk;

    rca_config_readback #(
        .XLEN(32), .NUM_RCAS(2), .NUM_READ_PORTS(5),
        .NUM_WRITE_PORTS(2), .NUM_IO_UNITS(8)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rca_sel(req_rca_sel), .req_kind(req_kind),
        .rd_en(rd_en), .rd_rca(rd_rca), .rd_kind(rd_kind), .rd_idx(rd_idx),
        .rd_data(rd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_err(rsp_err)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    logic [5:0]  rd_log[$];
    logic [31:0] mem [0:1][0:3][0:7];
    int          n_checks = 0;
    int          n_fail = 0;
    int          rd_cnt = 0;
    int          hs_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_rd_en"},     32'(rd_en),     32'd0);
        chk({tag, "_rd_rca"},    32'(rd_rca),    32'd0);
        chk({tag, "_rd_kind"},   32'(rd_kind),   32'd0);
        chk({tag, "_rd_idx"},    32'(rd_idx),    32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_data"},  rsp_data,       32'd0);
        chk({tag, "_rsp_last"},  32'(rsp_last),  32'd0);
        chk({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
    endtask

    function automatic exp_t mk(input logic [31:0] d, input logic l, input logic e);
        exp_t x;
        x.data = d;
        x.last = l;
        x.err  = e;
        return x;
    endfunction

    // Storage model: data appears the cycle after the read strobe.
    initial forever begin
        @(posedge clk);
        if (rd_en) begin
            rd_data <= mem[rd_rca][rd_kind][rd_idx];
            rd_cnt++;
            rd_log.push_back({rd_rca, rd_kind, rd_idx});
        end
    end

    // Response monitor: pops the scoreboard on each handshake, checks hold during stalls.
    initial begin
        logic        stall_prev;
        logic [31:0] stall_data;
        logic        stall_last;
        exp_t        e;
        stall_prev = 1'b0;
        stall_data = '0;
        stall_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && rsp_valid && stall_prev) begin
                chk("stall_data_hold", rsp_data, stall_data);
                chk("stall_last_hold", 32'(rsp_last), 32'(stall_last));
            end
            stall_prev = rst && rsp_valid && !rsp_ready;
            stall_data = rsp_data;
            stall_last = rsp_last;
            if (rst && rsp_valid && rsp_ready) begin
                hs_cnt++;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $error("FAIL unexpected_word: observed 0x%0h expected no word", rsp_data);
                end else begin
                    e = sb_q.pop_front();
                    $display("word data=0x%08h last=%0b err=%0b (exp 0x%08h %0b %0b)",
                             rsp_data, rsp_last, rsp_err, e.data, e.last, e.err);
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_last", 32'(rsp_last), 32'(e.last));
                    chk("rsp_err",  32'(rsp_err),  32'(e.err));
                end
            end
        end
    end

    // Issue a request, return the number of cycles from acceptance to first rsp_valid.
    task automatic do_req(input logic [3:0] sel, input logic [1:0] kind, output int lat);
        logic acc;
        acc = 1'b0;
        lat = 0;
        @(posedge clk);
        #1;
        req_valid   = 1'b1;
        req_rca_sel = sel;
        req_kind    = kind;
        for (int c = 0; c < 20 && !acc; c++) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
        end
        #1;
        req_valid = 1'b0;
        n_checks++;
        assert (acc) else begin
            n_fail++;
            $error("FAIL req_accept: observed not accepted expected accepted");
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        while (c < 200 && (sb_q.size() != 0 || !req_ready)) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_drained"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        int lat;
        int base;
        int hs_base;
        int any_valid;
        logic [31:0] k0 [0:4];

        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 4; k++)
                for (int i = 0; i < 8; i++)
                    mem[r][k][i] = $urandom;
        k0[0] = 32'h25; k0[1] = 32'h3; k0[2] = 32'h1F; k0[3] = 32'hFFFFFFE7; k0[4] = 32'h0;
        for (int i = 0; i < 5; i++) mem[1][0][i] = k0[i];
        mem[0][3][0] = 32'hA;
        mem[0][3][1] = 32'h5;
        mem[0][1][0] = 32'h3A;
        mem[0][1][1] = 32'h41;

        #2;
        chk_reset("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Kind 0, RCA 1: register addresses masked to 5 bits.
        rd_log.delete();
        base = rd_cnt;
        sb_q.push_back(mk(32'h5,  1'b0, 1'b0));
        sb_q.push_back(mk(32'h3,  1'b0, 1'b0));
        sb_q.push_back(mk(32'h1F, 1'b0, 1'b0));
        sb_q.push_back(mk(32'h7,  1'b0, 1'b0));
        sb_q.push_back(mk(32'h0,  1'b1, 1'b0));
        do_req(4'd1, 2'd0, lat);
        chk("k0_latency", 32'(lat), 32'd3);
        wait_idle("k0");
        chk("k0_rd_count", 32'(rd_cnt - base), 32'd5);
        chk("k0_rd_log_len", 32'(rd_log.size()), 32'd5);
        for (int i = 0; i < 5 && i < rd_log.size(); i++)
            chk("k0_rd_addr", 32'(rd_log[i]), 32'({1'b1, 2'd0, 3'(i)}));

        // Kind 2, RCA 0: full-width words, word 3 stalled for 4 cycles.
        base = rd_cnt;
        hs_base = hs_cnt;
        for (int i = 0; i < 8; i++) sb_q.push_back(mk(mem[0][2][i], i == 7, 1'b0));
        do_req(4'd0, 2'd2, lat);
        chk("k2_latency", 32'(lat), 32'd3);
        for (int c = 0; c < 50 && (hs_cnt - hs_base) < 2; c++) @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        for (int c = 0; c < 20 && !rsp_valid; c++) @(negedge clk);
        chk("k2_stall_word_valid", 32'(rsp_valid), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("k2_stall_rd_count", 32'(rd_cnt - base), 32'd3);
        rsp_ready = 1'b1;
        wait_idle("k2");
        chk("k2_rd_count", 32'(rd_cnt - base), 32'd8);

        // Kind 3: result-mux selects masked to 3 bits.
        sb_q.push_back(mk(32'h2, 1'b0, 1'b0));
        sb_q.push_back(mk(32'h5, 1'b1, 1'b0));
        do_req(4'd0, 2'd3, lat);
        chk("k3_latency", 32'(lat), 32'd3);
        wait_idle("k3");

        // Out-of-range RCA select: single error word, no storage access.
        base = rd_cnt;
        sb_q.push_back(mk(32'h0, 1'b1, 1'b1));
        do_req(4'd3, 2'd0, lat);
        chk("err_latency", 32'(lat), 32'd1);
        wait_idle("err");
        chk("err_rd_count", 32'(rd_cnt - base), 32'd0);
        chk("err_req_ready", 32'(req_ready), 32'd1);

        // Flush during SEND of word 2; a request presented with flush is held off.
        hs_base = hs_cnt;
        for (int i = 0; i < 8; i++) sb_q.push_back(mk(mem[1][2][i], i == 7, 1'b0));
        do_req(4'd1, 2'd2, lat);
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 20 && !rsp_valid; c++) @(negedge clk);
        chk("flush_words_before", 32'(hs_cnt - hs_base), 32'd1);
        @(posedge clk);
        #1;
        flush       = 1'b1;
        req_valid   = 1'b1;
        req_rca_sel = 4'd0;
        req_kind    = 2'd1;
        @(negedge clk);
        chk("flush_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        sb_q.delete();
        sb_q.push_back(mk(32'h1A, 1'b0, 1'b0));
        sb_q.push_back(mk(32'h01, 1'b1, 1'b0));
        base = rd_cnt;
        @(negedge clk);
        chk("flush_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("flush_idle_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("post_flush_busy", 32'(req_ready), 32'd0);
        chk("post_flush_rd_en", 32'(rd_en), 32'd1);
        wait_idle("post_flush");
        chk("post_flush_rd_count", 32'(rd_cnt - base), 32'd2);

        // Asynchronous reset pulsed during CAPTURE.
        @(posedge clk);
        #1;
        req_valid   = 1'b1;
        req_rca_sel = 4'd1;
        req_kind    = 2'd0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk_reset("mid_reset");
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        any_valid = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_valid) any_valid++;
        end
        chk("post_reset_no_valid", 32'(any_valid), 32'd0);
        chk("post_reset_req_ready", 32'(req_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
